// File: rtl/gated_reg_bank.sv
// Bank of independent gated data registers; each channel tracks d while enabled and
// clears, holds, or holds-then-times-out when disabled. Optional macro: GATED_REG_BANK_STATUS_EN.
module gated_reg_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int MODE        = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       expired
`ifdef GATED_REG_BANK_STATUS_EN
  ,
  output logic [$clog2(CHANNELS+1)-1:0] active_count
`endif
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

`ifdef GATED_REG_BANK_STATUS_EN
  localparam int AW = $clog2(CHANNELS + 1);
  logic [CHANNELS-1:0] valid_next;
  logic [AW-1:0]       count_sum;
`endif

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t           state, state_next;
      logic [CW-1:0]    count, count_next;
      logic [WIDTH-1:0] data, data_next;
      logic [WIDTH-1:0] din;
      logic             vld, vld_next;
      logic             expire, expire_next;

      assign din = d[gi*WIDTH +: WIDTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state  <= IDLE;
          count  <= '0;
          data   <= '0;
          vld    <= 1'b0;
          expire <= 1'b0;
        end else begin
          state  <= state_next;
          count  <= count_next;
          data   <= data_next;
          vld    <= vld_next;
          expire <= expire_next;
        end
      end

      always_comb begin
        state_next  = state;
        count_next  = count;
        data_next   = data;
        vld_next    = vld;
        expire_next = 1'b0;
        if (clear) begin
          state_next = IDLE;
          count_next = '0;
          data_next  = '0;
          vld_next   = 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (enable[gi]) begin
                state_next = TRACK;
                data_next  = din;
                vld_next   = 1'b1;
              end
            end
            TRACK: begin
              if (enable[gi]) begin
                data_next = din;
              end else if (MODE == 0) begin
                state_next = IDLE;
                data_next  = '0;
                vld_next   = 1'b0;
              end else begin
                state_next = HOLD;
                if (MODE == 2) count_next = CW'(HOLD_CYCLES - 1);
              end
            end
            HOLD: begin
              // Re-enable wins over timeout, so a capture on the final edge never pulses expired.
              if (enable[gi]) begin
                state_next = TRACK;
                data_next  = din;
                vld_next   = 1'b1;
              end else if (MODE == 2) begin
                if (count != '0) begin
                  count_next = count - CW'(1);
                end else begin
                  state_next  = IDLE;
                  data_next   = '0;
                  vld_next    = 1'b0;
                  expire_next = 1'b1;
                end
              end
            end
            default: begin
              state_next = IDLE;
              data_next  = '0;
              vld_next   = 1'b0;
            end
          endcase
        end
      end

      assign q[gi*WIDTH +: WIDTH] = data;
      assign valid[gi]            = vld;
      assign expired[gi]          = expire;
`ifdef GATED_REG_BANK_STATUS_EN
      assign valid_next[gi]       = vld_next;
`endif
    end
  endgenerate

`ifdef GATED_REG_BANK_STATUS_EN
  // Count is taken from next-state valids so it lines up with valid after the same edge.
  always_comb begin
    count_sum = '0;
    for (int i = 0; i < CHANNELS; i++) count_sum = count_sum + AW'(valid_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) active_count <= '0;
    else     active_count <= count_sum;
  end
`endif

endmodule

// File: doc/gated_reg_bank.md
GATED_REG_BANK -- requirements
Module: gated_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel.
REQ-002 Parameter CHANNELS, default 4: number of independent gated channels.
REQ-003 Parameter MODE, default 2: disable behaviour (0 = clear on disable, 1 = hold forever, 2 = hold then clear on timeout).
REQ-004 Parameter HOLD_CYCLES, default 4, legal range >= 1: hold length in MODE 2.
REQ-005 Port list (clock and reset are decided):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of all channels.
- enable  input  CHANNELS  per-channel capture enable.
- d  input  CHANNELS*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- q  output  CHANNELS*WIDTH  registered channel data; same packing as d.
- valid  output  CHANNELS  registered flag; high when q[i] holds captured data.
- expired  output  CHANNELS  registered one-cycle pulse when a MODE 2 hold times out.

Function
REQ-006 Each channel SHALL contain an independent FSM with states IDLE, TRACK and HOLD, plus a hold counter of width $clog2(HOLD_CYCLES+1).
REQ-007 All outputs SHALL be registered and SHALL have one-cycle latency from the sampling edge; the block SHALL contain no latches and no combinational path from inputs to outputs.
REQ-008 In IDLE: q=0 and valid=0; enable=1 SHALL move the channel to TRACK with q<=d and valid<=1.
REQ-009 In TRACK, enable=1 SHALL load q<=d on every edge.
REQ-010 In TRACK, enable=0 with MODE 0 SHALL move the channel to IDLE with q<=0 and valid<=0.
REQ-011 In TRACK, enable=0 with MODE 1 SHALL move the channel to HOLD; q and valid SHALL be held indefinitely.
REQ-012 In TRACK, enable=0 with MODE 2 SHALL move the channel to HOLD and load counter=HOLD_CYCLES-1; q and valid SHALL be held.
REQ-013 In HOLD, enable=1 SHALL move the channel to TRACK with q<=d; the counter is don't-care after this transition.
REQ-014 In HOLD with MODE 2 and enable=0: if counter>0, the counter SHALL decrement; if counter==0, the channel SHALL go to IDLE with q<=0, valid<=0 and expired[i]<=1 for exactly one cycle.
REQ-015 Consequence of REQ-012 and REQ-014: q is cleared on the (HOLD_CYCLES+1)-th consecutive edge sampling enable=0.
REQ-016 Edge case: if enable=1 on the edge where the counter is 0, the channel SHALL take TRACK, load d, and SHALL NOT pulse expired.
REQ-017 Edge case: clear=1 SHALL force every channel to IDLE (q=0, valid=0, counter=0, expired=0) and SHALL override enable on the same edge.
REQ-018 Edge case: a clear SHALL never produce an expired pulse.
REQ-019 Channels SHALL NOT interact; simultaneous enable or expiry on several channels SHALL be handled independently.

Reset
REQ-020 rst=1 SHALL asynchronously force all channels to IDLE, with q=0, valid=0, expired=0 and counters=0.
REQ-021 Reset asserted mid-hold SHALL abort the hold without an expired pulse.
REQ-022 After rst deasserts, the first rising edge SHALL evaluate inputs normally.

Configuration
REQ-023 Macro GATED_REG_BANK_STATUS_EN: when defined, the block SHALL add output active_count, width $clog2(CHANNELS+1), registered, equal to the number of channels whose valid will be 1 after the same edge (resets to 0).
REQ-024 Without GATED_REG_BANK_STATUS_EN, the active_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 MODE 0, ch0: enable=1 with d=0xA5 for 2 edges, then enable=0 -> q[7:0]=0xA5, valid[0]=1; one edge after disable, q[7:0]=0x00, valid[0]=0.
REQ-026 MODE 2, HOLD_CYCLES=4, ch1: capture d=0x3C, then enable=0 -> q holds 0x3C for 4 edges; the 5th edge gives q=0, valid[1]=0, and expired[1]=1 for exactly one cycle.
REQ-027 MODE 2, ch2: after capturing 0x11, re-assert enable with d=0x22 on the edge where counter==0 -> q=0x22, valid=1, expired[2] stays 0.
REQ-028 MODE 1, ch3: capture 0x7E, then enable=0 for 100 edges -> q=0x7E and valid=1 throughout; clear=1 together with enable=1 -> q=0 and valid=0 on the next edge.
REQ-029 Assert rst asynchronously between edges while ch0 is in HOLD -> q, valid and expired go to 0 immediately; no expired pulse follows.
REQ-030 With GATED_REG_BANK_STATUS_EN defined, enable channels 0, 1 and 3 -> active_count=3 after one edge; disable ch1 in MODE 0 -> active_count=2.
